// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures high/low durations of an asynchronous periodic input in CLK cycles.
// Optional input deglitch filter, enabled by defining PULSE_PERIOD_METER_DEGLITCH_EN.
module pulse_period_meter #(
  parameter int CNT_WIDTH       = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEGLITCH_COUNTS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN,
  output logic [CNT_WIDTH-1:0] HIGH_CNT,
  output logic [CNT_WIDTH-1:0] LOW_CNT,
  output logic                 VALID,
  output logic                 TIMEOUT,
  output logic [1:0]           fsm_state
);

  // VALID is a one-cycle strobe with no back-pressure: HIGH_CNT/LOW_CNT change only
  // in the cycle VALID is high and hold until the next VALID or reset.

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
  localparam int SETTLE = SYNC_STAGES + DEGLITCH_COUNTS + 1;
`else
  localparam int SETTLE = SYNC_STAGES + 1;
`endif
  localparam int SW = $clog2(SYNC_STAGES + DEGLITCH_COUNTS + 2);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_WIDTH-1:0]   counter;
  logic [CNT_WIDTH-1:0]   high_len;
  logic [SW-1:0]          settle_cnt;
  logic                   settled;

  always_ff @(posedge CLK) begin
    if (!RESET_N) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], IN};
  end
  assign synced = sync[SYNC_STAGES-1];

`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_COUNTS + 1);
  localparam logic [DW-1:0] DG_LAST = DW'(DEGLITCH_COUNTS - 1);
  logic          s_f;
  logic [DW-1:0] dg_cnt;

  // The filtered level follows only after DEGLITCH_COUNTS consecutive differing
  // samples, so rising and falling edges are delayed by the same amount.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s_f    <= 1'b0;
      dg_cnt <= '0;
    end else if (synced != s_f) begin
      if (dg_cnt == DG_LAST) begin
        s_f    <= synced;
        dg_cnt <= '0;
      end else begin
        dg_cnt <= dg_cnt + 1'b1;
      end
    end else begin
      dg_cnt <= '0;
    end
  end
  assign s = s_f;
`else
  assign s = synced;
`endif

  // The input path starts from zeros after reset; a high level already present
  // would look like a rising edge, so edges are ignored until the path holds real samples.
  always_ff @(posedge CLK) begin
    if (!RESET_N)                   settle_cnt <= '0;
    else if (settle_cnt != SETTLE_V) settle_cnt <= settle_cnt + 1'b1;
  end
  assign settled = (settle_cnt == SETTLE_V);

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      s_d      <= 1'b0;
      counter  <= '0;
      high_len <= '0;
      HIGH_CNT <= '0;
      LOW_CNT  <= '0;
      VALID    <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      s_d   <= s;
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && settled) begin
            counter <= CNT_WIDTH'(1);
            state   <= MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_len <= counter;
            counter  <= CNT_WIDTH'(1);
            state    <= MEAS_LOW;
          end else if (counter == CNT_MAX) begin
            TIMEOUT <= 1'b1;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            HIGH_CNT <= high_len;
            LOW_CNT  <= counter;
            VALID    <= 1'b1;
            TIMEOUT  <= 1'b0;
            counter  <= CNT_WIDTH'(1);
            state    <= MEAS_HIGH;
          end else if (counter == CNT_MAX) begin
            TIMEOUT <= 1'b1;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: drives run-length waveforms into pulse_period_meter and scores
// the reported high/low counts against a run-length reference model.
module tb_pulse_period_meter;

  localparam int SYNC = 2;
  localparam int DEG  = 4;
  localparam int W    = 16;
`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
  localparam int FILT = DEG;
`else
  localparam int FILT = 0;
`endif
  localparam int MINL  = (FILT > 0) ? DEG + 1 : 1;
  localparam int WAITN = SYNC + FILT + 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_sig = 1'b0;
  logic [W-1:0] high_cnt, low_cnt;
  logic         valid, timeout;
  logic [1:0]   fsm_state;
  logic [3:0]   h4, l4;
  logic         v4, t4;
  logic [1:0]   st4;

  pulse_period_meter #(.CNT_WIDTH(W), .SYNC_STAGES(SYNC), .DEGLITCH_COUNTS(DEG)) dut (
    .CLK(clk), .RESET_N(reset_n), .IN(in_sig), .HIGH_CNT(high_cnt), .LOW_CNT(low_cnt),
    .VALID(valid), .TIMEOUT(timeout), .fsm_state(fsm_state)
  );

  pulse_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(SYNC), .DEGLITCH_COUNTS(DEG)) dut4 (
    .CLK(clk), .RESET_N(reset_n), .IN(in_sig), .HIGH_CNT(h4), .LOW_CNT(l4),
    .VALID(v4), .TIMEOUT(t4), .fsm_state(st4)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // observed reports
  logic [2*W-1:0] obs_q[$];
  int             obs_cyc_q[$];
  int             v4_count = 0;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      obs_q.push_back({high_cnt, low_cnt});
      obs_cyc_q.push_back(cyc);
    end
    if (v4 === 1'b1) v4_count++;
  end

  // stimulus description and expected queue
  int             seg_lvl[$];
  int             seg_len[$];
  logic [2*W-1:0] exp_q[$];
  int             exp_rise_q[$];

  task automatic clear_segs();
    seg_lvl.delete();
    seg_len.delete();
    exp_q.delete();
    exp_rise_q.delete();
  endtask

  task automatic add_seg(input int lvl, input int len);
    seg_lvl.push_back(lvl);
    seg_len.push_back(len);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    obs_cyc_q.delete();
    v4_count = 0;
  endtask

  task automatic drive_level(input int lvl, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_sig = lvl[0];
    end
  endtask

  // drives all segments; base = posedge index at which the first segment is sampled
  task automatic drive_segments(output int base);
    bit first;
    first = 1'b1;
    base  = 0;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      for (int k = 0; k < seg_len[i]; k++) begin
        @(negedge clk);
        if (first) begin
          base  = cyc + 1;
          first = 1'b0;
        end
        in_sig = seg_lvl[i][0];
      end
    end
    repeat (SYNC + FILT + 4) @(negedge clk);
  endtask

  // Reference model: collapse the waveform into runs (a filtered build absorbs runs shorter
  // than DEG into the preceding level); every high run entered by a rise and followed by a
  // low run that ends in another rise is one report.
  task automatic build_expected(input int base);
    int rl[$];
    int rn[$];
    int rs[$];
    int lvl, t;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      lvl = seg_lvl[i];
      if (FILT > 0 && rl.size() > 0 && seg_len[i] < DEG) lvl = rl[rl.size()-1];
      if (rl.size() > 0 && rl[rl.size()-1] == lvl) rn[rn.size()-1] += seg_len[i];
      else begin
        rl.push_back(lvl);
        rn.push_back(seg_len[i]);
      end
    end
    t = base;
    for (int i = 0; i < rl.size(); i++) begin
      rs.push_back(t);
      t += rn[i];
    end
    for (int i = 1; i + 2 < rl.size(); i++) begin
      if (rl[i] == 1) begin
        exp_q.push_back({W'(rn[i]), W'(rn[i+1])});
        exp_rise_q.push_back(rs[i+2]);
      end
    end
  endtask

  // scoreboard: report count, report contents, and VALID latency after the closing rise
  task automatic score_scenario(input string name);
    int n, lat;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s report_count got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s report%0d high/low got %0d/%0d expected %0d/%0d", name, i,
                 obs_q[i][2*W-1:W], obs_q[i][W-1:0], exp_q[i][2*W-1:W], exp_q[i][W-1:0]);
      end
      tests++;
      lat = obs_cyc_q[i] - exp_rise_q[i];
      if (lat < SYNC + FILT || lat > SYNC + FILT + 2) begin
        fails++;
        $display("FAIL %s report%0d latency got %0d expected %0d..%0d", name, i, lat,
                 SYNC + FILT, SYNC + FILT + 2);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    bit bad;
    repeat (3) @(negedge clk);
    tests++;
    if ({high_cnt, low_cnt, valid, timeout, h4, l4, v4, t4} !== '0) begin
      fails++;
      $display("FAIL reset_state got h=%0d l=%0d v=%b t=%b st=%0d expected all zero",
               high_cnt, low_cnt, valid, timeout, fsm_state);
    end
    reset_n = 1'b1;
    clear_segs();
    add_seg(0, 8); add_seg(1, 10); add_seg(0, 6); add_seg(1, 3);
    drive_segments(base);
    tests++;
    if (obs_q.size() != 1 || high_cnt !== W'(10)) begin
      fails++;
      $display("FAIL pre_reset_report got count=%0d high=%0d expected 1/10", obs_q.size(), high_cnt);
    end
    @(negedge clk);
    reset_n = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_sig = ~in_sig;
      tests++;
      if ({high_cnt, low_cnt, valid, timeout} !== '0) begin
        fails++;
        $display("FAIL reset_hold cycle%0d got h=%0d l=%0d v=%b t=%b st=%0d expected zero",
                 i, high_cnt, low_cnt, valid, timeout, st4);
      end
    end
    in_sig  = 1'b0;
    reset_n = 1'b1;
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_period_10_6();
    int base;
    apply_reset(2);
    clear_segs();
    add_seg(0, 8);
    for (int p = 0; p < 4; p++) begin add_seg(1, 10); add_seg(0, 6); end
    add_seg(1, 4);
    drive_segments(base);
    build_expected(base);
    score_scenario("period_10_6");
    tests++;
    if (obs_q.size() < 2 || obs_q[0] !== {W'(10), W'(6)} || obs_cyc_q[1] - obs_cyc_q[0] != 16) begin
      fails++;
      $display("FAIL period_10_6_spacing got count=%0d expected first 10/6 and 16-cycle spacing", obs_q.size());
    end
  endtask

  task automatic test_high_out_of_reset();
    int base;
    in_sig = 1'b1;
    apply_reset(3);
    clear_segs();
    add_seg(1, 7);
    for (int p = 0; p < 3; p++) begin add_seg(0, 5); add_seg(1, 9); end
    add_seg(0, 5); add_seg(1, 5);
    drive_segments(base);
    build_expected(base);
    score_scenario("high_out_of_reset");
    tests++;
    if (obs_q.size() < 1 || obs_q[0] !== {W'(9), W'(5)}) begin
      fails++;
      $display("FAIL first_partial_ignored got count=%0d expected first report 9/5", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    int h1, tl;
    h1 = (FILT > 0) ? DEG : 3;
    tl = (FILT > 0) ? DEG + 1 : 2;
    in_sig = 1'b0;
    apply_reset(2);
    drive_level(0, 8);
    drive_level(1, h1);
    drive_level(0, 20 + 2 * FILT);
    tests++;
    if (t4 !== 1'b1 || v4_count != 0) begin
      fails++;
      $display("FAIL timeout_set got t=%b valids=%0d expected 1/0", t4, v4_count);
    end
    drive_level(1, 4); drive_level(0, tl); drive_level(1, 4 + WAITN);
    tests++;
    if (v4_count != 1 || h4 !== 4'(4) || l4 !== 4'(tl) || t4 !== 1'b0) begin
      fails++;
      $display("FAIL timeout_recover got v=%0d h=%0d l=%0d t=%b expected 1/4/%0d/0", v4_count, h4, l4, t4, tl);
    end
    drive_level(0, 15); drive_level(1, 2 + WAITN);
    tests++;
    if (v4_count != 2 || h4 !== 4'(4 + WAITN) || l4 !== 4'(15) || t4 !== 1'b0) begin
      fails++;
      $display("FAIL edge_beats_saturation got v=%0d h=%0d l=%0d t=%b expected 2/%0d/15/0",
               v4_count, h4, l4, t4, 4 + WAITN);
    end
    drive_level(0, 16 + WAITN);
    tests++;
    if (v4_count != 2 || t4 !== 1'b1 || h4 !== 4'(4 + WAITN) || l4 !== 4'(15)) begin
      fails++;
      $display("FAIL saturation_holds got v=%0d h=%0d l=%0d t=%b expected 2/%0d/15/1",
               v4_count, h4, l4, t4, 4 + WAITN);
    end
  endtask

  task automatic test_reset_mid_low();
    int base;
    in_sig = 1'b0;
    apply_reset(2);
    clear_segs();
    add_seg(0, 8); add_seg(1, 10); add_seg(0, 6); add_seg(1, 10);
    drive_segments(base);
    drive_level(0, 3);
    tests++;
    if (obs_q.size() != 1 || obs_q[0] !== {W'(10), W'(6)}) begin
      fails++;
      $display("FAIL before_mid_reset got count=%0d expected one 10/6 report", obs_q.size());
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tests++;
    if ({high_cnt, low_cnt, valid, timeout} !== '0) begin
      fails++;
      $display("FAIL mid_reset_clear got h=%0d l=%0d v=%b t=%b expected zero", high_cnt, low_cnt, valid, timeout);
    end
    obs_q.delete();
    obs_cyc_q.delete();
    clear_segs();
    add_seg(0, 8); add_seg(1, 7); add_seg(0, 5); add_seg(1, 11); add_seg(0, 4); add_seg(1, 5);
    drive_segments(base);
    build_expected(base);
    score_scenario("after_mid_reset");
  endtask

  task automatic test_glitch();
    int base;
    in_sig = 1'b0;
    apply_reset(2);
    clear_segs();
    add_seg(0, 8); add_seg(1, 9); add_seg(0, 2); add_seg(1, 9); add_seg(0, 10); add_seg(1, 5);
    drive_segments(base);
    build_expected(base);
    score_scenario("glitch");
    tests++;
`ifdef PULSE_PERIOD_METER_DEGLITCH_EN
    if (obs_q.size() != 1 || obs_q[0] !== {W'(20), W'(10)}) begin
      fails++;
      $display("FAIL glitch_filtered got count=%0d expected one 20/10 report", obs_q.size());
    end
`else
    if (obs_q.size() != 2 || obs_q[0] !== {W'(9), W'(2)} || obs_q[1] !== {W'(9), W'(10)}) begin
      fails++;
      $display("FAIL glitch_measured got count=%0d expected 9/2 then 9/10", obs_q.size());
    end
`endif
  endtask

  task automatic test_random();
    int base, nper;
    for (int r = 0; r < 6; r++) begin
      in_sig = 1'b0;
      apply_reset(2);
      clear_segs();
      add_seg(0, 8 + $urandom_range(0, 5));
      nper = $urandom_range(3, 8);
      for (int p = 0; p < nper; p++) begin
        add_seg(1, $urandom_range(MINL, 40));
        add_seg(0, $urandom_range(MINL, 40));
      end
      add_seg(1, MINL + 2);
      drive_segments(base);
      build_expected(base);
      score_scenario($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_period_10_6();
    test_high_out_of_reset();
    test_timeout();
    test_reset_mid_low();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
